// File: rtl/mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_dump_ctrl
// Purpose  : MEM-stage pass-through to data memory; on debug request, dumps all
//            memory words byte-wise (MSB first) to the UART over valid/ready.
//            Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte.
// Revision : 1.0
// ============================================================================
module mem_dump_ctrl #(
   parameter int NB_DATA    = 32,
   parameter int NB_ADDRESS = 6,
   parameter int NB_BYTE    = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_dump_start,
   input  logic                  i_cpu_halted,
   input  logic [NB_ADDRESS-1:0] i_cpu_r_addr,
   input  logic                  i_cpu_r_en,
   input  logic [1:0]            i_cpu_r_addressing,
   input  logic [NB_ADDRESS-1:0] i_cpu_w_addr,
   input  logic [NB_DATA-1:0]    i_cpu_w_data,
   input  logic                  i_cpu_w_en,
   input  logic [1:0]            i_cpu_w_addressing,
   output logic [NB_DATA-1:0]    o_cpu_r_data,
   output logic [NB_ADDRESS-1:0] o_mem_r_addr,
   output logic                  o_mem_r_en,
   output logic [1:0]            o_mem_r_addressing,
   output logic [NB_ADDRESS-1:0] o_mem_w_addr,
   output logic [NB_DATA-1:0]    o_mem_w_data,
   output logic                  o_mem_w_en,
   output logic [1:0]            o_mem_w_addressing,
   input  logic [NB_DATA-1:0]    i_mem_r_data,
   output logic [NB_BYTE-1:0]    o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int c_BYTES_PER_WORD = NB_DATA / NB_BYTE;
   localparam int c_NB_WORD_LSB    = $clog2(c_BYTES_PER_WORD);
   localparam int c_NB_COUNT       = NB_ADDRESS - c_NB_WORD_LSB;
   localparam int c_NB_IDX         = (c_BYTES_PER_WORD > 1) ? $clog2(c_BYTES_PER_WORD) : 1;

   localparam logic [c_NB_COUNT-1:0] c_LAST_WORD = '1;
   localparam logic [c_NB_IDX-1:0]   c_LAST_BYTE = c_NB_IDX'(c_BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ      = 3'd1,
      ST_WAIT      = 3'd2,
      ST_SEND      = 3'd3,
      ST_DONE      = 3'd4
`ifdef MEM_DUMP_CHECKSUM_EN
      ,
      ST_SEND_CSUM = 3'd5
`endif
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [c_NB_COUNT-1:0]   r_word_cnt;
   logic [NB_DATA-1:0]      r_shift;
   logic [c_NB_IDX-1:0]     r_byte_idx;
   logic [NB_BYTE-1:0]      r_tx_data;
   logic                    r_tx_valid;
   logic                    r_busy;
   logic                    r_done;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [NB_BYTE-1:0]      r_csum;
`endif

   logic w_accept;
   logic w_xfer;
   logic w_last_byte;
   logic w_last_word;

   assign w_accept    = i_dump_start && i_cpu_halted;
   assign w_xfer      = r_tx_valid && i_tx_ready;
   assign w_last_byte = (r_byte_idx == c_LAST_BYTE);
   assign w_last_word = (r_word_cnt == c_LAST_WORD);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      o_mem_r_addr       = i_cpu_r_addr;
      o_mem_r_en         = i_cpu_r_en;
      o_mem_r_addressing = i_cpu_r_addressing;
      o_mem_w_addr       = i_cpu_w_addr;
      o_mem_w_data       = i_cpu_w_data;
      o_mem_w_en         = i_cpu_w_en;
      o_mem_w_addressing = i_cpu_w_addressing;
      o_cpu_r_data       = i_mem_r_data;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ST_READ;
            end
         end
         ST_READ: w_state_next = ST_WAIT;
         ST_WAIT: w_state_next = ST_SEND;
         ST_SEND: begin
            if (w_xfer && w_last_byte) begin
               if (w_last_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  w_state_next = ST_SEND_CSUM;
`else
                  w_state_next = ST_DONE;
`endif
               end else begin
                  w_state_next = ST_READ;
               end
            end
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         ST_SEND_CSUM: begin
            if (w_xfer) begin
               w_state_next = ST_DONE;
            end
         end
`endif
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase

      // Dump owns the memory: CPU requests are dropped, only word reads issued.
      if (r_state != ST_IDLE) begin
         o_mem_r_addr       = {r_word_cnt, {c_NB_WORD_LSB{1'b0}}};
         o_mem_r_en         = (r_state == ST_READ);
         o_mem_r_addressing = 2'b00;
         o_mem_w_addr       = '0;
         o_mem_w_data       = '0;
         o_mem_w_en         = 1'b0;
         o_mem_w_addressing = 2'b00;
         o_cpu_r_data       = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word_cnt <= '0;
         r_shift    <= '0;
         r_byte_idx <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         r_done <= (w_state_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_busy     <= 1'b1;
                  r_word_cnt <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                  r_csum     <= '0;
`endif
               end
            end
            ST_WAIT: begin
               r_shift    <= i_mem_r_data;
               r_byte_idx <= '0;
               r_tx_data  <= i_mem_r_data[NB_DATA-1 -: NB_BYTE];
               r_tx_valid <= 1'b1;
            end
            ST_SEND: begin
               if (w_xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  r_csum <= r_csum ^ r_tx_data;
`endif
                  if (w_last_byte) begin
                     r_tx_valid <= 1'b0;
                     if (!w_last_word) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                     end
`ifdef MEM_DUMP_CHECKSUM_EN
                     else begin
                        // Checksum must include the byte being accepted now.
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= r_csum ^ r_tx_data;
                     end
`endif
                  end else begin
                     r_byte_idx <= r_byte_idx + 1'b1;
                     r_shift    <= r_shift << NB_BYTE;
                     r_tx_data  <= r_shift[NB_DATA-NB_BYTE-1 -: NB_BYTE];
                  end
               end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_SEND_CSUM: begin
               if (w_xfer) begin
                  r_tx_valid <= 1'b0;
               end
            end
`endif
            ST_DONE: begin
               r_busy     <= 1'b0;
               r_word_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_tx_data  = r_tx_data;
   assign o_tx_valid = r_tx_valid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for mem_dump_ctrl: word memory model, byte scoreboard, directed steps.
module tb_mem_dump_ctrl;

   localparam int NB_DATA    = 32;
   localparam int NB_ADDRESS = 6;
   localparam int NB_BYTE    = 8;
`ifdef MEM_DUMP_CHECKSUM_EN
   localparam int c_N_BYTES  = 65;
`else
   localparam int c_N_BYTES  = 64;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  dump_start;
   logic                  cpu_halted;
   logic [NB_ADDRESS-1:0] cpu_r_addr;
   logic                  cpu_r_en;
   logic [1:0]            cpu_r_addressing;
   logic [NB_ADDRESS-1:0] cpu_w_addr;
   logic [NB_DATA-1:0]    cpu_w_data;
   logic                  cpu_w_en;
   logic [1:0]            cpu_w_addressing;
   logic [NB_DATA-1:0]    cpu_r_data;
   logic [NB_ADDRESS-1:0] mem_r_addr;
   logic                  mem_r_en;
   logic [1:0]            mem_r_addressing;
   logic [NB_ADDRESS-1:0] mem_w_addr;
   logic [NB_DATA-1:0]    mem_w_data;
   logic                  mem_w_en;
   logic [1:0]            mem_w_addressing;
   logic [NB_DATA-1:0]    mem_r_data;
   logic [NB_BYTE-1:0]    tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  busy;
   logic                  done;

   always #5 clk = ~clk;

   mem_dump_ctrl #(
      .NB_DATA    (NB_DATA),
      .NB_ADDRESS (NB_ADDRESS),
      .NB_BYTE    (NB_BYTE)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_dump_start       (dump_start),
      .i_cpu_halted       (cpu_halted),
      .i_cpu_r_addr       (cpu_r_addr),
      .i_cpu_r_en         (cpu_r_en),
      .i_cpu_r_addressing (cpu_r_addressing),
      .i_cpu_w_addr       (cpu_w_addr),
      .i_cpu_w_data       (cpu_w_data),
      .i_cpu_w_en         (cpu_w_en),
      .i_cpu_w_addressing (cpu_w_addressing),
      .o_cpu_r_data       (cpu_r_data),
      .o_mem_r_addr       (mem_r_addr),
      .o_mem_r_en         (mem_r_en),
      .o_mem_r_addressing (mem_r_addressing),
      .o_mem_w_addr       (mem_w_addr),
      .o_mem_w_data       (mem_w_data),
      .o_mem_w_en         (mem_w_en),
      .o_mem_w_addressing (mem_w_addressing),
      .i_mem_r_data       (mem_r_data),
      .o_tx_data          (tx_data),
      .o_tx_valid         (tx_valid),
      .i_tx_ready         (tx_ready),
      .o_busy             (busy),
      .o_done             (done)
   );

   // Word-organised data memory, one-cycle read latency.
   logic [NB_DATA-1:0] mem [0:15];
   always @(posedge clk) begin
      if (mem_w_en) mem[mem_w_addr[5:2]] <= mem_w_data;
      if (mem_r_en) mem_r_data <= mem[mem_r_addr[5:2]];
   end

   int         tests    = 0;
   int         fails    = 0;
   int         xfers    = 0;
   int         done_cnt = 0;
   int         exp_addr = 0;
   logic       w_leak   = 1'b0;
   logic [7:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected();
      sb.delete();
      sb.push_back(8'h01);
      sb.push_back(8'h23);
      sb.push_back(8'hab);
      sb.push_back(8'hcd);
      for (int i = 4; i < 64; i++) sb.push_back(8'h00);
`ifdef MEM_DUMP_CHECKSUM_EN
      sb.push_back(8'h44);
`endif
      exp_addr = 0;
      xfers    = 0;
      done_cnt = 0;
   endtask

   task automatic start_dump();
      cpu_halted = 1'b1;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      int n = 0;
      while (!done && n < max_cycles) begin
         step();
         n++;
      end
      check("done_seen", done, 1'b1);
   endtask

   // Monitor: transfers, read addresses, write leaks and done pulses.
   always @(negedge clk) begin
      if (rst_n && busy && mem_r_en) begin
         check("rd_addr", mem_r_addr, exp_addr);
         exp_addr = exp_addr + 4;
      end
      if (rst_n && busy && mem_w_en) w_leak = 1'b1;
      if (tx_valid && tx_ready) begin
         xfers++;
         tests++;
         assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL sb_extra: observed byte %0h expected none", tx_data);
         end
         if (sb.size() > 0) check("tx_byte", tx_data, sb.pop_front());
      end
      if (done) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem_r_data       = '0;
      rst_n            = 1'b0;
      dump_start       = 1'b0;
      cpu_halted       = 1'b0;
      cpu_r_addr       = '0;
      cpu_r_en         = 1'b0;
      cpu_r_addressing = 2'b00;
      cpu_w_addr       = '0;
      cpu_w_data       = '0;
      cpu_w_en         = 1'b0;
      cpu_w_addressing = 2'b00;
      tx_ready         = 1'b1;
      repeat (3) step();
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst_n = 1'b1;
      step();

      // Pass-through write then read
      cpu_w_addr = 6'd0;
      cpu_w_data = 32'h0123abcd;
      cpu_w_en   = 1'b1;
      #1;
      check("pt_w_en", mem_w_en, 1'b1);
      check("pt_w_addr", mem_w_addr, 6'd0);
      check("pt_w_data", mem_w_data, 32'h0123abcd);
      check("pt_w_mode", mem_w_addressing, 2'b00);
      step();
      cpu_w_en         = 1'b0;
      cpu_r_addr       = 6'd0;
      cpu_r_addressing = 2'b11;
      cpu_r_en         = 1'b1;
      #1;
      check("pt_r_en", mem_r_en, 1'b1);
      check("pt_r_addr", mem_r_addr, 6'd0);
      check("pt_r_mode", mem_r_addressing, 2'b11);
      step();
      cpu_r_en         = 1'b0;
      cpu_r_addressing = 2'b00;
      check("pt_r_data", cpu_r_data, 32'h0123abcd);

      // Start without halt is ignored
      cpu_halted = 1'b0;
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      repeat (4) step();
      check("gate_busy", busy, 1'b0);
      check("gate_valid", tx_valid, 1'b0);
      check("gate_xfers", xfers, 0);

      // Full dump with latency, isolation, restart-while-busy and halt drop
      push_expected();
      w_leak = 1'b0;
      start_dump();
      check("lat_busy", busy, 1'b1);
      check("lat_valid_c1", tx_valid, 1'b0);
      cpu_w_en   = 1'b1;
      cpu_w_addr = 6'd8;
      cpu_w_data = 32'hdeadbeef;
      cpu_r_en   = 1'b1;
      cpu_r_addr = 6'd0;
      #1;
      check("iso_w_en", mem_w_en, 1'b0);
      check("iso_r_data", cpu_r_data, 32'h0);
      check("iso_r_mode", mem_r_addressing, 2'b00);
      step();
      check("lat_valid_c2", tx_valid, 1'b0);
      step();
      check("lat_valid_c3", tx_valid, 1'b1);
      check("lat_first_byte", tx_data, 8'h01);
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      cpu_halted = 1'b0;
      cpu_w_en   = 1'b0;
      cpu_r_en   = 1'b0;
      wait_done(600);
      step();
      check("d1_busy_after", busy, 1'b0);
      check("d1_done_after", done, 1'b0);
      check("d1_done_cnt", done_cnt, 1);
      check("d1_xfers", xfers, c_N_BYTES);
      check("d1_sb_left", sb.size(), 0);
      check("iso_w_leak", w_leak, 1'b0);
      cpu_r_addr = 6'd8;
      cpu_r_en   = 1'b1;
      step();
      cpu_r_en = 1'b0;
      check("iso_mem8", cpu_r_data, 32'h0);

      // Backpressure on byte 2
      push_expected();
      start_dump();
      n = 0;
      while (!(tx_valid && tx_data == 8'hab) && n < 20) begin
         step();
         n++;
      end
      check("bp_reach", tx_data, 8'hab);
      tx_ready = 1'b0;
      repeat (5) begin
         step();
         check("bp_hold_data", tx_data, 8'hab);
         check("bp_hold_valid", tx_valid, 1'b1);
      end
      tx_ready = 1'b1;
      wait_done(600);
      step();
      check("bp_xfers", xfers, c_N_BYTES);
      check("bp_done_cnt", done_cnt, 1);
      check("bp_sb_left", sb.size(), 0);

      // Reset during SEND of word 5
      push_expected();
      start_dump();
      n = 0;
      while (xfers < 21 && n < 300) begin
         step();
         n++;
      end
      check("rst_reach", xfers, 21);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_valid", tx_valid, 1'b0);
      sb.delete();
      step();
      step();
      check("mid_rst_no_done", done_cnt, 0);
      rst_n = 1'b1;
      step();

      // Fresh dump restarts at address 0
      push_expected();
      start_dump();
      check("re_r_en", mem_r_en, 1'b1);
      check("re_r_addr", mem_r_addr, 6'd0);
      wait_done(600);
      step();
      check("re_xfers", xfers, c_N_BYTES);
      check("re_done_cnt", done_cnt, 1);
      check("re_sb_left", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_dump_ctrl.md
Name: mem_dump_ctrl

Overview:
- Sits between the pipeline MEM stage and the data memory.
- In normal operation it passes CPU read/write requests straight through to the memory.
- On a debug dump request, while the CPU is halted, it takes ownership of the memory and reads every word sequentially. It then streams the contents byte by byte to the debug UART transmitter over a valid/ready handshake.

Parameters:
- NB_DATA, 32, memory data bus width in bits (multiple of NB_BYTE).
- NB_ADDRESS, 6, byte address width; memory holds 2^NB_ADDRESS bytes.
- NB_BYTE, 8, width of one transmitted byte.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dump_start  in  1  single-cycle dump request from the debug unit.
- i_cpu_halted  in  1  pipeline halted; gates acceptance of i_dump_start.
- i_cpu_r_addr  in  NB_ADDRESS  CPU read byte address.
- i_cpu_r_en  in  1  CPU read enable.
- i_cpu_r_addressing  in  2  CPU read mode: 00 word, 01 half, 11 byte.
- i_cpu_w_addr  in  NB_ADDRESS  CPU write byte address.
- i_cpu_w_data  in  NB_DATA  CPU write data.
- i_cpu_w_en  in  1  CPU write enable.
- i_cpu_w_addressing  in  2  CPU write mode (same encoding as read).
- o_cpu_r_data  out  NB_DATA  read data returned to the CPU.
- o_mem_r_addr  out  NB_ADDRESS  memory read address.
- o_mem_r_en  out  1  memory read enable.
- o_mem_r_addressing  out  2  memory read mode.
- o_mem_w_addr  out  NB_ADDRESS  memory write address.
- o_mem_w_data  out  NB_DATA  memory write data.
- o_mem_w_en  out  1  memory write enable.
- o_mem_w_addressing  out  2  memory write mode.
- i_mem_r_data  in  NB_DATA  memory read data, valid one cycle after o_mem_r_en.
- o_tx_data  out  NB_BYTE  byte to the UART transmitter.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  UART accepts the byte this cycle.
- o_busy  out  1  dump owns the memory; the pipeline must stall.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: all state returns to IDLE asynchronously.
  - Registered outputs at reset: o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
  - Word counter and shift register clear to 0.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - Memory ports are combinational pass-through of the CPU ports; o_cpu_r_data = i_mem_r_data.
  - i_dump_start && i_cpu_halted -> READ, with word counter = 0 and o_busy=1.
  - i_dump_start without i_cpu_halted is ignored.
- Memory ownership while not IDLE:
  - o_mem_w_en = 0; CPU requests are dropped; o_cpu_r_data = 0.
  - o_mem_r_addressing = 00 (word reads).
- READ: o_mem_r_en=1, o_mem_r_addr = counter*4 (low two bits 0). -> WAIT.
- WAIT: capture i_mem_r_data into the shift register; load byte index 0. -> SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = current byte, MSB byte first.
  - o_tx_data is held stable while o_tx_valid && !i_tx_ready.
  - On i_tx_ready: advance the byte index.
  - After byte NB_DATA/NB_BYTE-1: if counter == 2^NB_ADDRESS/4 - 1 -> DONE; otherwise counter++ -> READ.
- DONE: o_done=1 for exactly one cycle, o_tx_valid=0, o_busy=0 on the next cycle. -> IDLE.
- Latency: first o_tx_valid appears 3 cycles after i_dump_start is accepted. Minimum per word = 2 + NB_DATA/NB_BYTE cycles.
- Boundaries:
  - i_dump_start while busy is ignored.
  - i_cpu_halted dropping mid-dump does not abort; the dump completes.
  - Counter wraps only via DONE; no address exceeds 2^NB_ADDRESS-4.
  - i_rst_n asserted mid-dump aborts immediately; no o_done pulse.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every transmitted byte is kept; it clears on dump start.
  - After the last data byte, an extra SEND_CSUM state emits the checksum byte with the same handshake, then -> DONE.
  - Total bytes = 2^NB_ADDRESS + 1.
- Undefined: no checksum register or state; exactly 2^NB_ADDRESS bytes are sent.

Test Plan:
- Pass-through: IDLE, CPU writes 32'h0123abcd at addr 0 (mode 00), then reads -> o_mem_w_* mirror the CPU inputs; o_cpu_r_data = 32'h0123abcd one cycle after read enable.
- Gated start: i_dump_start with i_cpu_halted=0 -> state stays IDLE, o_busy=0, no o_tx_valid.
- Full dump, i_tx_ready=1 constantly, word0=32'h0123abcd, others 0:
  - Bytes are 01,23,ab,cd followed by 60 zeros.
  - o_done pulses once; 64 valid-ready transfers (65 with MEM_DUMP_CHECKSUM_EN, last byte = 8'h44).
- Backpressure: i_tx_ready low 5 cycles on byte 2 -> o_tx_data held at 8'hab, o_tx_valid held high, no byte skipped or repeated.
- Isolation: CPU w_en=1 at addr 8 during dump -> o_mem_w_en stays 0; memory word at addr 8 unchanged after o_done.
- Reset mid-dump: i_rst_n low during SEND of word 5 -> o_busy=0, o_tx_valid=0 immediately, no o_done. A new dump starts again at addr 0.
